// File: rtl/perf_pkg.sv
// Shared constants and helpers for the performance counter bank.
package perf_pkg;

    localparam int MODE_WRAP     = 0;
    localparam int MODE_SATURATE = 1;

    // Read-select width; a single-channel bank still gets a 1-bit select.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One live event counter with a sticky overflow flag.
module perf_counter_cell
    import perf_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             INIT,
    input  logic             INC,
    output logic [WIDTH-1:0] COUNT,
    output logic             OVF
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic at_max;
    assign at_max = &COUNT;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            COUNT <= '0;
            OVF   <= 1'b0;
        end else if (INIT) begin
            COUNT <= '0;
            OVF   <= 1'b0;
        end else if (INC) begin
            if (at_max) begin
                OVF <= 1'b1;
                // Saturating mode simply leaves COUNT at all-ones.
                if (SATURATE == MODE_WRAP)
                    COUNT <= '0;
            end else begin
                COUNT <= COUNT + ONE;
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of CHANNELS event counters with an atomic shadow snapshot and registered read port.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int SATURATE = MODE_WRAP,
    parameter int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                INIT,
    input  logic [CHANNELS-1:0] EN,
    input  logic [CHANNELS-1:0] EVENT,
    input  logic                SNAP,
    input  logic [SEL_W-1:0]    RD_SEL,
    output logic [WIDTH-1:0]    RD_DATA,
    output logic [CHANNELS-1:0] OVF,
    output logic                SNAP_VALID
);

    logic [CHANNELS-1:0][WIDTH-1:0] live;
    logic [CHANNELS-1:0][WIDTH-1:0] shadow;
    logic [WIDTH-1:0]               rd_next;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
        perf_counter_cell #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_cell (
            .CLOCK (CLOCK),
            .RESET (RESET),
            .INIT  (INIT),
            .INC   (EN[i] & EVENT[i]),
            .COUNT (live[i]),
            .OVF   (OVF[i])
        );
    end

    // Selects beyond the last channel fall through to zero.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (32'(RD_SEL) == i)
                rd_next = shadow[i];
    end

    // Shadow samples pre-edge live values, so INIT/EVENT on the same edge are excluded.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            shadow     <= '0;
            RD_DATA    <= '0;
            SNAP_VALID <= 1'b0;
        end else begin
            if (SNAP)
                shadow <= live;
            RD_DATA    <= rd_next;
            SNAP_VALID <= SNAP_VALID | SNAP;
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench: a wrapping and a saturating 4x4-bit bank driven in lockstep.
module tb_perf_counter_bank;

    logic       CLOCK;
    logic       rst, init, snap;
    logic [3:0] en, ev;
    logic [2:0] rd_sel;
    logic [3:0] rd_w, rd_s, ovf_w, ovf_s;
    logic       sv_w, sv_s;
    logic [7:0] v;

    int checks = 0;
    int errors = 0;

    perf_counter_bank #(.CHANNELS(4), .WIDTH(4), .SATURATE(0), .SEL_W(3)) u_wrap (
        .CLOCK(CLOCK), .RESET(rst), .INIT(init), .EN(en), .EVENT(ev), .SNAP(snap),
        .RD_SEL(rd_sel), .RD_DATA(rd_w), .OVF(ovf_w), .SNAP_VALID(sv_w)
    );

    perf_counter_bank #(.CHANNELS(4), .WIDTH(4), .SATURATE(1), .SEL_W(3)) u_sat (
        .CLOCK(CLOCK), .RESET(rst), .INIT(init), .EN(en), .EVENT(ev), .SNAP(snap),
        .RD_SEL(rd_sel), .RD_DATA(rd_s), .OVF(ovf_s), .SNAP_VALID(sv_s)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Returns {wrap, saturate} read data for one shadow channel.
    task automatic rd(input int ch, output logic [7:0] val);
        rd_sel = 3'(ch);
        snap   = 1'b0;
        tick();
        val = {rd_w, rd_s};
    endtask

    task automatic do_init();
        init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    task automatic do_snap();
        snap = 1'b1;
        tick();
        snap = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; init = 0; snap = 0; en = 0; ev = 0; rd_sel = 0;
        tick();
        rst = 1'b0;
        checks++;
        if ({rd_w, rd_s} !== 8'h00) begin
            errors++; $display("FAIL reset_rd: got %h exp 00", {rd_w, rd_s});
        end
        checks++;
        if ({ovf_w, ovf_s} !== 8'h00) begin
            errors++; $display("FAIL reset_ovf: got %h exp 00", {ovf_w, ovf_s});
        end
        checks++;
        if ({sv_w, sv_s} !== 2'b00) begin
            errors++; $display("FAIL reset_snap_valid: got %b exp 00", {sv_w, sv_s});
        end
    endtask

    task automatic test_basic_count();
        en = 4'b0001; ev = 4'b0001;
        ticks(5);
        ev = 4'b0000;
        do_snap();
        checks++;
        if ({sv_w, sv_s} !== 2'b11) begin
            errors++; $display("FAIL basic_snap_valid: got %b exp 11", {sv_w, sv_s});
        end
        rd(0, v);
        checks++;
        if (v !== {4'd5, 4'd5}) begin
            errors++; $display("FAIL basic_ch0: got %h exp 55", v);
        end
        for (int c = 1; c < 4; c++) begin
            rd(c, v);
            checks++;
            if (v !== 8'h00) begin
                errors++; $display("FAIL basic_ch%0d: got %h exp 00", c, v);
            end
        end
    endtask

    task automatic test_enable_mask();
        logic [3:0] exp_v [4];
        exp_v = '{4'd3, 4'd0, 4'd3, 4'd0};
        do_init();
        en = 4'b0101; ev = 4'b1111;
        ticks(3);
        ev = 4'b0000;
        do_snap();
        for (int c = 0; c < 4; c++) begin
            rd(c, v);
            checks++;
            if (v !== {exp_v[c], exp_v[c]}) begin
                errors++; $display("FAIL enable_ch%0d: got %h exp %h", c, v, {exp_v[c], exp_v[c]});
            end
        end
    endtask

    task automatic test_overflow();
        do_init();
        en = 4'b0010; ev = 4'b0010;
        ticks(15);
        ev = 4'b0000;
        checks++;
        if ({ovf_w, ovf_s} !== 8'h00) begin
            errors++; $display("FAIL ovf_at_15: got %h exp 00", {ovf_w, ovf_s});
        end
        do_snap();
        rd(1, v);
        checks++;
        if (v !== {4'd15, 4'd15}) begin
            errors++; $display("FAIL count_15: got %h exp ff", v);
        end
        ev = 4'b0010;
        ticks(2);
        ev = 4'b0000;
        checks++;
        if ({ovf_w, ovf_s} !== {4'b0010, 4'b0010}) begin
            errors++; $display("FAIL ovf_at_17: got %h exp 22", {ovf_w, ovf_s});
        end
        do_snap();
        rd(1, v);
        checks++;
        if (v !== {4'd1, 4'd15}) begin
            errors++; $display("FAIL count_17: got %h exp 1f", v);
        end
        ticks(3);
        checks++;
        if ({ovf_w, ovf_s} !== {4'b0010, 4'b0010}) begin
            errors++; $display("FAIL ovf_sticky: got %h exp 22", {ovf_w, ovf_s});
        end
    endtask

    task automatic test_init_snap();
        en = 4'b0001; ev = 4'b0001;
        ticks(9);
        init = 1'b1; snap = 1'b1;
        tick();
        init = 1'b0; snap = 1'b0; ev = 4'b0000;
        checks++;
        if ({ovf_w, ovf_s} !== 8'h00) begin
            errors++; $display("FAIL init_ovf: got %h exp 00", {ovf_w, ovf_s});
        end
        rd(0, v);
        checks++;
        if (v !== {4'd9, 4'd9}) begin
            errors++; $display("FAIL init_shadow_ch0: got %h exp 99", v);
        end
        rd(1, v);
        checks++;
        if (v !== {4'd1, 4'd15}) begin
            errors++; $display("FAIL init_shadow_ch1: got %h exp 1f", v);
        end
        ev = 4'b0001;
        ticks(2);
        ev = 4'b0000;
        do_snap();
        rd(0, v);
        checks++;
        if (v !== {4'd2, 4'd2}) begin
            errors++; $display("FAIL init_live_ch0: got %h exp 22", v);
        end
        rd(1, v);
        checks++;
        if (v !== 8'h00) begin
            errors++; $display("FAIL init_live_ch1: got %h exp 00", v);
        end
    endtask

    task automatic test_back_to_back();
        do_init();
        en = 4'b0100; ev = 4'b0100;
        ticks(4);
        ev = 4'b0000;
        do_snap();
        ev = 4'b0100;
        ticks(3);
        // SNAP, read and an event all on one edge
        rd_sel = 3'd2; snap = 1'b1;
        tick();
        checks++;
        if ({rd_w, rd_s} !== {4'd4, 4'd4}) begin
            errors++; $display("FAIL collide_old: got %h exp 44", {rd_w, rd_s});
        end
        snap = 1'b0; ev = 4'b0000;
        tick();
        checks++;
        if ({rd_w, rd_s} !== {4'd7, 4'd7}) begin
            errors++; $display("FAIL collide_new: got %h exp 77", {rd_w, rd_s});
        end
        snap = 1'b1;
        tick();
        snap = 1'b0;
        tick();
        checks++;
        if ({rd_w, rd_s} !== {4'd8, 4'd8}) begin
            errors++; $display("FAIL collide_event_after: got %h exp 88", {rd_w, rd_s});
        end
        rd(4, v);
        checks++;
        if (v !== 8'h00) begin
            errors++; $display("FAIL rd_sel_4: got %h exp 00", v);
        end
        rd(7, v);
        checks++;
        if (v !== 8'h00) begin
            errors++; $display("FAIL rd_sel_7: got %h exp 00", v);
        end
    endtask

    task automatic test_async_reset();
        do_init();
        en = 4'b1111; ev = 4'b1111;
        ticks(3);
        do_snap();
        rd(0, v);
        checks++;
        if (v !== {4'd3, 4'd3} || {sv_w, sv_s} !== 2'b11) begin
            errors++; $display("FAIL pre_reset: got %h/%b exp 33/11", v, {sv_w, sv_s});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rd_w, rd_s, ovf_w, ovf_s} !== 16'h0000 || {sv_w, sv_s} !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: got rd %h ovf %h sv %b exp 0", {rd_w, rd_s}, {ovf_w, ovf_s}, {sv_w, sv_s});
        end
        rst = 1'b0;
        en = 4'b0001; ev = 4'b0001;
        ticks(2);
        ev = 4'b0000;
        do_snap();
        rd(0, v);
        checks++;
        if (v !== {4'd2, 4'd2}) begin
            errors++; $display("FAIL restart_ch0: got %h exp 22", v);
        end
        rd(3, v);
        checks++;
        if (v !== 8'h00) begin
            errors++; $display("FAIL restart_ch3: got %h exp 00", v);
        end
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_enable_mask();
        test_overflow();
        test_init_snap();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
